// File: rtl/pipeline_controller.sv
// ID-stage decoder, ID/EX control register, stall/flush write enables and halt-drain FSM.
// Optional internal load-use hazard detection is enabled by defining PIPELINE_CONTROLLER_LOAD_USE_EN.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int RADDR_W      = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         Opcode,
  input  logic               InstValid,
  input  logic [RADDR_W-1:0] Rs1,
  input  logic [RADDR_W-1:0] Rs2,
  input  logic [RADDR_W-1:0] Rd,
  input  logic               StallIn,
  input  logic               Flush,
  output logic               PCWriteEn,
  output logic               IFIDWriteEn,
  output logic               ExALUSrc,
  output logic               ExMemtoReg,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExBranch,
  output logic               ExJump,
  output logic               ExJumpReg,
  output logic [1:0]         ExALUOp,
  output logic [RADDR_W-1:0] ExRd,
  output logic               ExValid,
  output logic               IllegalOp,
  output logic               Halted
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t             state, state_next;
  logic [3:0]         count, count_next;
  ctrl_t              dec_ctrl, ex_ctrl, ex_ctrl_next;
  logic               dec_legal, dec_halt, dec_rs2_used;
  logic [RADDR_W-1:0] ex_rd, ex_rd_next;
  logic               ex_valid, ex_valid_next;
  logic               illegal, illegal_next;
  logic               halted;
  logic               hazard, stall, advance, write_en;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left one unassigned would infer a latch.
    dec_ctrl     = '0;
    dec_legal    = 1'b1;
    dec_halt     = 1'b0;
    dec_rs2_used = 1'b0;
    case (Opcode)
      OP_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        dec_rs2_used       = 1'b1;
      end
      OP_I: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_rs2_used       = 1'b1;
      end
      OP_BR: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
        dec_rs2_used    = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = 1'b1;
      end
      OP_JALR: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.jump_reg  = 1'b1;
        dec_ctrl.alu_op    = 2'b11;
      end
      OP_HALT: dec_halt  = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef PIPELINE_CONTROLLER_LOAD_USE_EN
  // A load in EX whose destination feeds the ID instruction holds ID for one cycle.
  logic rs1_hit, rs2_hit;
  assign rs1_hit = (Opcode != OP_JAL) && (ex_rd == Rs1);
  assign rs2_hit = dec_rs2_used && (ex_rd == Rs2);
  assign hazard  = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && InstValid
                   && (rs1_hit || rs2_hit);
`else
  logic unused_rs;
  assign unused_rs = ^{Rs1, Rs2, dec_rs2_used};
  assign hazard    = 1'b0;
`endif

  assign stall   = StallIn || hazard;
  assign advance = (state == ST_RUN) && InstValid && !stall && !Flush;

  always_comb begin
    state_next = state;
    count_next = count;
    write_en   = 1'b1;
    case (state)
      ST_RUN: begin
        write_en = !stall || Flush;
        if (advance && dec_halt) begin
          state_next = ST_DRAIN;
          count_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A flush here means the HALT was fetched down a mispredicted path.
        if (Flush) begin
          state_next = ST_RUN;
          count_next = '0;
        end else begin
          write_en = 1'b0;
          if (count == '0) state_next = ST_HALTED;
          else             count_next = count - 4'd1;
        end
      end
      ST_HALTED: write_en = 1'b0;
      default: begin
        state_next = ST_RUN;
        count_next = '0;
      end
    endcase
    // While reset is held the core still tracks the external stall only.
    if (!reset_n) write_en = !StallIn;
  end

  assign PCWriteEn   = write_en;
  assign IFIDWriteEn = write_en;

  always_comb begin
    ex_ctrl_next  = '0;
    ex_rd_next    = '0;
    ex_valid_next = 1'b0;
    if (advance && dec_legal && !dec_halt) begin
      ex_ctrl_next  = dec_ctrl;
      ex_rd_next    = Rd;
      ex_valid_next = 1'b1;
    end
  end

  assign illegal_next = advance && !dec_legal;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      count    <= '0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
      ex_valid <= 1'b0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      ex_ctrl  <= ex_ctrl_next;
      ex_rd    <= ex_rd_next;
      ex_valid <= ex_valid_next;
      illegal  <= illegal_next;
      halted   <= (state_next == ST_HALTED);
    end
  end

  assign ExALUSrc   = ex_ctrl.alu_src;
  assign ExMemtoReg = ex_ctrl.mem_to_reg;
  assign ExRegWrite = ex_ctrl.reg_write;
  assign ExMemRead  = ex_ctrl.mem_read;
  assign ExMemWrite = ex_ctrl.mem_write;
  assign ExBranch   = ex_ctrl.branch;
  assign ExJump     = ex_ctrl.jump;
  assign ExJumpReg  = ex_ctrl.jump_reg;
  assign ExALUOp    = ex_ctrl.alu_op;
  assign ExRd       = ex_rd;
  assign ExValid    = ex_valid;
  assign IllegalOp  = illegal;
  assign Halted     = halted;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus randomized traffic
// compared against a cycle-level reference model (halt tracked as a due-cycle timestamp).
module tb_pipeline_controller;

  localparam int D  = 3;
  localparam int AW = 5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [6:0]    Opcode;
  logic          InstValid, StallIn, Flush;
  logic [AW-1:0] Rs1, Rs2, Rd;
  logic          PCWriteEn, IFIDWriteEn;
  logic          ExALUSrc, ExMemtoReg, ExRegWrite, ExMemRead, ExMemWrite;
  logic          ExBranch, ExJump, ExJumpReg;
  logic [1:0]    ExALUOp;
  logic [AW-1:0] ExRd;
  logic          ExValid, IllegalOp, Halted;

  pipeline_controller #(.DRAIN_CYCLES(D), .RADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .InstValid(InstValid),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .StallIn(StallIn), .Flush(Flush),
    .PCWriteEn(PCWriteEn), .IFIDWriteEn(IFIDWriteEn),
    .ExALUSrc(ExALUSrc), .ExMemtoReg(ExMemtoReg), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExBranch(ExBranch),
    .ExJump(ExJump), .ExJumpReg(ExJumpReg), .ExALUOp(ExALUOp), .ExRd(ExRd),
    .ExValid(ExValid), .IllegalOp(IllegalOp), .Halted(Halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ID/EX contents plus the cycle at which Halted is due (-1 = no HALT pending).
  logic [9:0]    m_ctrl;
  logic [AW-1:0] m_rd;
  logic          m_valid, m_ill;
  int            m_cycle, m_halt_at;
  logic          obs_pc, obs_ifid;
  logic [6:0]    ops [7];
  logic [9:0]    obs_ctrl;

  assign obs_ctrl = {ExALUSrc, ExMemtoReg, ExRegWrite, ExMemRead, ExMemWrite,
                     ExBranch, ExJump, ExJumpReg, ExALUOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {legal, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, jump_reg, alu_op}
  function automatic logic [10:0] ref_decode(input logic [6:0] op);
    case (op)
      OP_R:    return {1'b1, 8'b0010_0000, 2'b10};
      OP_I:    return {1'b1, 8'b1010_0000, 2'b10};
      OP_LW:   return {1'b1, 8'b1111_0000, 2'b00};
      OP_SW:   return {1'b1, 8'b1000_1000, 2'b00};
      OP_BR:   return {1'b1, 8'b0000_0100, 2'b01};
      OP_JAL:  return {1'b1, 8'b0010_0010, 2'b00};
      OP_JALR: return {1'b1, 8'b1010_0011, 2'b11};
      OP_HALT: return {1'b1, 8'b0000_0000, 2'b00};
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic ref_uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BR);
  endfunction

  function automatic logic ref_halted();
    return (m_halt_at >= 0) && (m_cycle >= m_halt_at);
  endfunction

  task automatic model_reset();
    m_ctrl    = '0;
    m_rd      = '0;
    m_valid   = 1'b0;
    m_ill     = 1'b0;
    m_cycle   = 0;
    m_halt_at = -1;
  endtask

  // One ID-stage cycle: drive, check the combinational enables, clock, check registered outputs.
  task automatic cycle(input logic [6:0] op, input logic iv, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                       input logic st, input logic fl);
    logic [10:0] dec;
    logic        haz, stl, running, draining, adv, exp_we;
    Opcode = op; InstValid = iv; Rs1 = rs1; Rs2 = rs2; Rd = rd; StallIn = st; Flush = fl;
    dec      = ref_decode(op);
    running  = (m_halt_at < 0);
    draining = !running && !ref_halted();
    haz      = 1'b0;
`ifdef PIPELINE_CONTROLLER_LOAD_USE_EN
    haz = m_valid && m_ctrl[6] && (m_rd != '0) && iv
          && (((op != OP_JAL) && (m_rd == rs1)) || (ref_uses_rs2(op) && (m_rd == rs2)));
`endif
    stl    = st || haz;
    exp_we = running ? (!stl || fl) : (draining && fl);
    #1;
    obs_pc   = PCWriteEn;
    obs_ifid = IFIDWriteEn;
    check("pc_we", PCWriteEn, exp_we);
    check("ifid_we", IFIDWriteEn, exp_we);
    adv = running && iv && !stl && !fl;
    @(posedge clk);
    m_cycle++;
    if (adv && dec[10] && (op != OP_HALT)) begin
      m_ctrl = dec[9:0]; m_rd = rd; m_valid = 1'b1;
    end else begin
      m_ctrl = '0; m_rd = '0; m_valid = 1'b0;
    end
    m_ill = adv && !dec[10];
    if (draining && fl)                 m_halt_at = -1;
    else if (adv && (op == OP_HALT))    m_halt_at = m_cycle + D;
    #1;
    check("ex_ctrl", obs_ctrl, m_ctrl);
    check("ex_rd", ExRd, m_rd);
    check("ex_valid", ExValid, m_valid);
    check("illegal_op", IllegalOp, m_ill);
    check("halted", Halted, ref_halted());
  endtask

  // Asynchronous reset: effects are checked before any clock edge occurs.
  task automatic do_reset(input logic stall_val);
    StallIn = stall_val; Flush = 1'b1; InstValid = 1'b1; Opcode = OP_R; Rd = 5'd9;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_halted", Halted, 1'b0);
    check("rst_pc_we", PCWriteEn, !stall_val);
    check("rst_ifid_we", IFIDWriteEn, !stall_val);
    check("rst_ex_ctrl", obs_ctrl, 10'b0);
    check("rst_ex_valid", ExValid, 1'b0);
    check("rst_ex_rd", ExRd, 5'd0);
    check("rst_illegal", IllegalOp, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", ExValid, 1'b0);
    InstValid = 1'b0; Flush = 1'b0; StallIn = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
    reset_n = 1'b1; Opcode = '0; InstValid = 1'b0; StallIn = 1'b0; Flush = 1'b0;
    Rs1 = '0; Rs2 = '0; Rd = '0;
    model_reset();
    #2;
    do_reset(1'b1);

    // R-type issues with its control bundle one cycle later.
    cycle(OP_R, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
    check("add_pc_we", obs_pc, 1'b1);
    check("add_regwrite", ExRegWrite, 1'b1);
    check("add_aluop", ExALUOp, 2'b10);
    check("add_valid", ExValid, 1'b1);
    check("add_rd", ExRd, 5'd7);

    // Load followed by a dependent ADD.
    cycle(OP_LW, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    cycle(OP_R, 1'b1, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0);
`ifdef PIPELINE_CONTROLLER_LOAD_USE_EN
    check("lu_stall_pc", obs_pc, 1'b0);
    check("lu_bubble", ExValid, 1'b0);
    cycle(OP_R, 1'b1, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0);
    check("lu_issue_pc", obs_pc, 1'b1);
    check("lu_issue", ExValid, 1'b1);
    check("lu_issue_rd", ExRd, 5'd3);
`else
    check("lu_nostall_pc", obs_pc, 1'b1);
    check("lu_issue", ExValid, 1'b1);
    check("lu_issue_rd", ExRd, 5'd3);
`endif

    // Flush overrides stall.
    cycle(OP_R, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    check("sf_pc_we", obs_pc, 1'b1);
    check("sf_ifid_we", obs_ifid, 1'b1);
    check("sf_bubble", ExValid, 1'b0);

    // HALT drains for D cycles, then Halted stays high.
    cycle(OP_HALT, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("halt_bubble", ExValid, 1'b0);
    check("halt_not_yet", Halted, 1'b0);
    for (int i = 1; i <= D; i++) begin
      cycle(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      check("drain_pc_we", obs_pc, 1'b0);
      check("halt_timing", Halted, i == D);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      check("halted_stays", Halted, 1'b1);
      check("halted_pc_we", obs_pc, 1'b0);
    end
    do_reset(1'b0);

    // HALT cancelled by a flush one cycle later.
    cycle(OP_HALT, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    check("cancel_pc_we", obs_pc, 1'b1);
    for (int i = 0; i < D + 3; i++) begin
      cycle(OP_I, 1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
      check("cancel_no_halt", Halted, 1'b0);
      check("cancel_run_pc", obs_pc, 1'b1);
    end

    // Illegal opcode: pulse only when it would have advanced.
    cycle(7'b0000000, 1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    check("ill_pulse", IllegalOp, 1'b1);
    check("ill_bubble", ExValid, 1'b0);
    cycle(OP_R, 1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    check("ill_one_cycle", IllegalOp, 1'b0);
    cycle(7'b0000000, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    check("ill_stalled", IllegalOp, 1'b0);

    // Reset mid-drain returns to RUN immediately (checked inside do_reset).
    cycle(OP_HALT, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    check("pre_reset_drain_pc", obs_pc, 1'b0);
    do_reset(1'b0);

    // Randomized traffic in several reset episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 300; i++) begin
        int         r;
        logic [6:0] op;
        r = $urandom_range(0, 99);
        if (r < 85)      op = ops[$urandom_range(0, 6)];
        else if (r < 89) op = OP_HALT;
        else             op = 7'($urandom);
        cycle(op, $urandom_range(0, 99) < 85,
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12);
        if (((m_halt_at >= 0) && (m_cycle >= m_halt_at + 5)) || ($urandom_range(0, 199) == 0))
          do_reset(1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
